// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : One line-request channel (request, masked write data, read
//               response). Clients and the arbiter's memory side use the
//               master modport; the arbiter's client sides and the memory use
//               the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ADDR_BITS-1:0]     req_addr;
  logic                     req_rw;
  logic                     req_data_valid;
  logic                     req_data_ready;
  logic [DATA_BITS-1:0]     req_data_bits;
  logic [DATA_BITS/8-1:0]   req_data_mask;
  logic                     resp_valid;
  logic [DATA_BITS-1:0]     resp_data;

  modport master (
    output req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    input  req_ready, req_data_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    output req_ready, req_data_ready, resp_valid, resp_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter between the instruction cache and the data
//               cache onto one main-memory port. Read owners are kept in an
//               in-order tag FIFO so responses are routed back to the issuer.
//               Split write handshakes lock the channel until both halves end.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int TAG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_arbiter_if.slave         ic,
  mem_arbiter_if.slave         dc,
  mem_arbiter_if.master        mem,
  output logic                 err_orphan_o
);

  localparam int PTR_W     = $clog2(TAG_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int MASK_BITS = DATA_BITS / 8;

  typedef enum logic {
    ARB   = 1'b0,
    WLOCK = 1'b1
  } state_t;

  state_t                 state_q;
  logic                   last_grant_q;   // 0 = ic, 1 = dc
  logic                   lock_q;         // client owning the split write
  logic                   addr_done_q;
  logic                   data_done_q;
  logic                   err_q;
  logic [TAG_DEPTH-1:0]   owner_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;

  logic                   run;
  logic                   full;
  logic                   ic_elig;
  logic                   dc_elig;
  logic                   grant;
  logic                   sel_valid;
  logic                   sel_rw;
  logic                   sel_dvalid;
  logic [ADDR_BITS-1:0]   sel_addr;
  logic [DATA_BITS-1:0]   sel_data;
  logic [MASK_BITS-1:0]   sel_mask;
  logic                   req_valid_w;
  logic                   write_grant;
  logic                   data_valid_w;
  logic                   addr_hs;
  logic                   data_hs;
  logic                   push;
  logic                   pop;
  logic                   head_owner;

  assign run = ~reset;

  // Grant selection, request muxing and handshake/FIFO strobes
  always_comb begin
    full    = (count_q == CNT_W'(TAG_DEPTH));
    ic_elig = ic.req_valid & (ic.req_rw | ~full);
    dc_elig = dc.req_valid & (dc.req_rw | ~full);

    if (state_q == WLOCK)        grant = lock_q;
    else if (ic_elig && dc_elig) grant = ~last_grant_q;
    else                         grant = dc_elig;

    sel_valid  = grant ? dc.req_valid      : ic.req_valid;
    sel_rw     = grant ? dc.req_rw         : ic.req_rw;
    sel_dvalid = grant ? dc.req_data_valid : ic.req_data_valid;
    sel_addr   = grant ? dc.req_addr       : ic.req_addr;
    sel_data   = grant ? dc.req_data_bits  : ic.req_data_bits;
    sel_mask   = grant ? dc.req_data_mask  : ic.req_data_mask;

    if (state_q == WLOCK) begin
      // Locked client: the half already accepted is masked off
      req_valid_w = sel_valid & ~addr_done_q;
      write_grant = 1'b1;
    end else begin
      req_valid_w = grant ? dc_elig : ic_elig;
      write_grant = req_valid_w & sel_rw;
    end
    data_valid_w = write_grant & sel_dvalid & ~data_done_q;

    addr_hs    = run & req_valid_w & mem.req_ready;
    data_hs    = run & data_valid_w & mem.req_data_ready;
    push       = addr_hs & ~sel_rw & (state_q == ARB);
    pop        = run & mem.resp_valid & (count_q != '0);
    head_owner = owner_q[rd_ptr_q];
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Outputs are forced low while reset is held
  assign mem.req_valid      = run & req_valid_w;
  assign mem.req_addr       = run ? sel_addr : '0;
  assign mem.req_rw         = run & sel_rw;
  assign mem.req_data_valid = run & data_valid_w;
  assign mem.req_data_bits  = run ? sel_data : '0;
  assign mem.req_data_mask  = run ? sel_mask : '0;

  assign ic.req_ready       = addr_hs & ~grant;
  assign dc.req_ready       = addr_hs & grant;
  assign ic.req_data_ready  = data_hs & ~grant;
  assign dc.req_data_ready  = data_hs & grant;

  assign ic.resp_valid      = pop & ~head_owner;
  assign dc.resp_valid      = pop & head_owner;
  assign ic.resp_data       = run ? mem.resp_data : '0;
  assign dc.resp_data       = run ? mem.resp_data : '0;

  assign err_orphan_o       = run & err_q;

  // Arbitration FSM, tag FIFO and sticky orphan flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB;
      last_grant_q <= 1'b0;
      lock_q       <= 1'b0;
      addr_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      err_q        <= 1'b0;
      owner_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr_q] <= grant;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      if (mem.resp_valid && (count_q == '0)) begin
        err_q <= 1'b1;
      end

      case (state_q)
        ARB: begin
          if (push) begin
            last_grant_q <= grant;
          end else if (write_grant) begin
            if (addr_hs && data_hs) begin
              last_grant_q <= grant;
            end else if (addr_hs || data_hs) begin
              addr_done_q <= addr_hs;
              data_done_q <= data_hs;
              lock_q      <= grant;
              state_q     <= WLOCK;
            end
          end
        end
        WLOCK: begin
          if ((addr_done_q || addr_hs) && (data_done_q || data_hs)) begin
            addr_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            last_grant_q <= lock_q;
            state_q      <= ARB;
          end else begin
            if (addr_hs) addr_done_q <= 1'b1;
            if (data_hs) data_done_q <= 1'b1;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed scenarios plus a randomized run of mem_arbiter
//               checked against a transaction-level model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AB    = 28;
  localparam int DB    = 128;
  localparam int MB    = DB / 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_orphan;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) ic_bus ();
  mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) dc_bus ();
  mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) mem_bus ();

  mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .TAG_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .ic           (ic_bus),
    .dc           (dc_bus),
    .mem          (mem_bus),
    .err_orphan_o (err_orphan)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_bus.req_valid = 0; ic_bus.req_addr = '0; ic_bus.req_rw = 0;
    ic_bus.req_data_valid = 0; ic_bus.req_data_bits = '0; ic_bus.req_data_mask = '0;
    dc_bus.req_valid = 0; dc_bus.req_addr = '0; dc_bus.req_rw = 0;
    dc_bus.req_data_valid = 0; dc_bus.req_data_bits = '0; dc_bus.req_data_mask = '0;
    mem_bus.req_ready = 0; mem_bus.req_data_ready = 0;
    mem_bus.resp_valid = 0; mem_bus.resp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    idle_inputs();
    reset = 1;
    ic_bus.req_valid = 1; ic_bus.req_addr = 28'h123;
    dc_bus.req_valid = 1; mem_bus.req_ready = 1; mem_bus.resp_valid = 1;
    #1;
    obs = {mem_bus.req_valid, mem_bus.req_data_valid, ic_bus.req_ready, dc_bus.req_ready,
           ic_bus.resp_valid, dc_bus.resp_valid, err_orphan};
    n_total++;
    if (obs !== 7'b0) $display("FAIL reset_outputs: got %b expected 0000000", obs);
    else n_pass++;
    n_total++;
    if (mem_bus.req_addr !== '0) $display("FAIL reset_addr: got %h expected 0", mem_bus.req_addr);
    else n_pass++;
    tick();
    idle_inputs();
    reset = 0;
    #1;
    n_total++;
    if ({err_orphan, mem_bus.req_valid} !== 2'b00)
      $display("FAIL post_reset: got %b expected 00", {err_orphan, mem_bus.req_valid});
    else n_pass++;
    tick();
  endtask

  task automatic test_single_read();
    logic [DB-1:0] pat;
    do_reset();
    dc_bus.req_valid = 1; dc_bus.req_addr = 28'h0000010; dc_bus.req_rw = 0;
    mem_bus.req_ready = 1;
    #1;
    n_total++;
    if ({mem_bus.req_valid, mem_bus.req_rw, dc_bus.req_ready, ic_bus.req_ready} !== 4'b1010)
      $display("FAIL single_read_req: got %b expected 1010",
               {mem_bus.req_valid, mem_bus.req_rw, dc_bus.req_ready, ic_bus.req_ready});
    else n_pass++;
    n_total++;
    if (mem_bus.req_addr !== 28'h0000010)
      $display("FAIL single_read_addr: got %h expected 0000010", mem_bus.req_addr);
    else n_pass++;
    tick();
    dc_bus.req_valid = 0;
    tick();
    tick();
    pat = {16{8'hA5}};
    mem_bus.resp_valid = 1; mem_bus.resp_data = pat;
    #1;
    n_total++;
    if ({ic_bus.resp_valid, dc_bus.resp_valid} !== 2'b01)
      $display("FAIL single_read_resp: got %b expected 01", {ic_bus.resp_valid, dc_bus.resp_valid});
    else n_pass++;
    n_total++;
    if (dc_bus.resp_data !== pat)
      $display("FAIL single_read_data: got %h expected %h", dc_bus.resp_data, pat);
    else n_pass++;
    tick();
    mem_bus.resp_valid = 0;
  endtask

  task automatic test_contention();
    logic exp_dc;
    do_reset();
    ic_bus.req_valid = 1; ic_bus.req_addr = 28'h100;
    dc_bus.req_valid = 1; dc_bus.req_addr = 28'h200;
    mem_bus.req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      exp_dc = (i % 2 == 0);
      #1;
      n_total++;
      if ({ic_bus.req_ready, dc_bus.req_ready} !== {~exp_dc, exp_dc})
        $display("FAIL contention_grant[%0d]: got %b expected %b", i,
                 {ic_bus.req_ready, dc_bus.req_ready}, {~exp_dc, exp_dc});
      else n_pass++;
      n_total++;
      if (mem_bus.req_addr !== (exp_dc ? 28'h200 : 28'h100))
        $display("FAIL contention_addr[%0d]: got %h expected %h", i, mem_bus.req_addr,
                 exp_dc ? 28'h200 : 28'h100);
      else n_pass++;
      tick();
    end
    ic_bus.req_valid = 0; dc_bus.req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      exp_dc = (i % 2 == 0);
      mem_bus.resp_valid = 1;
      #1;
      n_total++;
      if ({ic_bus.resp_valid, dc_bus.resp_valid} !== {~exp_dc, exp_dc})
        $display("FAIL contention_resp[%0d]: got %b expected %b", i,
                 {ic_bus.resp_valid, dc_bus.resp_valid}, {~exp_dc, exp_dc});
      else n_pass++;
      tick();
    end
    mem_bus.resp_valid = 0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    ic_bus.req_valid = 1; ic_bus.req_addr = 28'h300; mem_bus.req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if (ic_bus.req_ready !== 1'b1) $display("FAIL full_fill[%0d]: got %b expected 1", i, ic_bus.req_ready);
      else n_pass++;
      tick();
    end
    dc_bus.req_valid = 1; dc_bus.req_rw = 1; dc_bus.req_addr = 28'h400;
    dc_bus.req_data_valid = 1; dc_bus.req_data_bits = {4{$urandom}}; dc_bus.req_data_mask = 16'hFFFF;
    mem_bus.req_data_ready = 1;
    #1;
    n_total++;
    if ({ic_bus.req_ready, dc_bus.req_ready, dc_bus.req_data_ready, mem_bus.req_rw} !== 4'b0111)
      $display("FAIL full_write: got %b expected 0111",
               {ic_bus.req_ready, dc_bus.req_ready, dc_bus.req_data_ready, mem_bus.req_rw});
    else n_pass++;
    n_total++;
    if (mem_bus.req_data_bits !== dc_bus.req_data_bits)
      $display("FAIL full_write_data: got %h expected %h", mem_bus.req_data_bits, dc_bus.req_data_bits);
    else n_pass++;
    tick();
    dc_bus.req_valid = 0; dc_bus.req_data_valid = 0; dc_bus.req_rw = 0;
    mem_bus.resp_valid = 1;
    #1;
    n_total++;
    if ({ic_bus.req_ready, ic_bus.resp_valid} !== 2'b01)
      $display("FAIL full_pop_cycle: got %b expected 01", {ic_bus.req_ready, ic_bus.resp_valid});
    else n_pass++;
    tick();
    mem_bus.resp_valid = 0;
    #1;
    n_total++;
    if (ic_bus.req_ready !== 1'b1) $display("FAIL full_after_pop: got %b expected 1", ic_bus.req_ready);
    else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_split_write();
    logic [4:0] obs;
    logic [4:0] exp_t [5] = '{5'b11001, 5'b00001, 5'b00001, 5'b00011, 5'b10100};
    do_reset();
    dc_bus.req_valid = 1; dc_bus.req_rw = 1; dc_bus.req_addr = 28'h500;
    dc_bus.req_data_valid = 1; dc_bus.req_data_mask = 16'h00FF;
    ic_bus.req_valid = 1; ic_bus.req_addr = 28'h600;
    mem_bus.req_ready = 1; mem_bus.req_data_ready = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) mem_bus.req_data_ready = 1;
      #1;
      obs = {mem_bus.req_valid, dc_bus.req_ready, ic_bus.req_ready,
             dc_bus.req_data_ready, mem_bus.req_data_valid};
      n_total++;
      if (obs !== exp_t[c]) $display("FAIL split_write[%0d]: got %b expected %b", c, obs, exp_t[c]);
      else n_pass++;
      if (c == 4) begin
        n_total++;
        if (mem_bus.req_addr !== 28'h600)
          $display("FAIL split_write_next: got %h expected 0000600", mem_bus.req_addr);
        else n_pass++;
      end
      tick();
      if (c == 0) dc_bus.req_valid = 0;
      if (c == 3) begin dc_bus.req_data_valid = 0; dc_bus.req_rw = 0; end
    end
    idle_inputs();
  endtask

  task automatic test_push_pop_wrap();
    int q[$];
    int own;
    do_reset();
    mem_bus.req_ready = 1;
    for (int i = 0; i < 12; i++) begin
      own = (i < 10) ? int'($urandom_range(0, 1)) : -1;
      ic_bus.req_valid = (own == 0); ic_bus.req_addr = AB'(i);
      dc_bus.req_valid = (own == 1); dc_bus.req_addr = AB'(i);
      mem_bus.resp_valid = (i >= 2);
      #1;
      if (own >= 0) begin
        n_total++;
        if ({ic_bus.req_ready, dc_bus.req_ready} !== ((own == 1) ? 2'b01 : 2'b10))
          $display("FAIL pushpop_accept[%0d]: got %b expected %b", i,
                   {ic_bus.req_ready, dc_bus.req_ready}, (own == 1) ? 2'b01 : 2'b10);
        else n_pass++;
      end
      if (i >= 2) begin
        n_total++;
        if ({ic_bus.resp_valid, dc_bus.resp_valid} !== ((q[0] == 1) ? 2'b01 : 2'b10))
          $display("FAIL pushpop_order[%0d]: got %b expected %b", i,
                   {ic_bus.resp_valid, dc_bus.resp_valid}, (q[0] == 1) ? 2'b01 : 2'b10);
        else n_pass++;
        void'(q.pop_front());
      end
      if (own >= 0) q.push_back(own);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_orphan_reset();
    do_reset();
    ic_bus.req_valid = 1; mem_bus.req_ready = 1;
    tick();
    ic_bus.req_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    #1;
    n_total++;
    if (err_orphan !== 1'b0) $display("FAIL orphan_clear: got %b expected 0", err_orphan);
    else n_pass++;
    mem_bus.resp_valid = 1;
    #1;
    n_total++;
    if ({ic_bus.resp_valid, dc_bus.resp_valid} !== 2'b00)
      $display("FAIL orphan_resp: got %b expected 00", {ic_bus.resp_valid, dc_bus.resp_valid});
    else n_pass++;
    tick();
    mem_bus.resp_valid = 0;
    #1;
    n_total++;
    if (err_orphan !== 1'b1) $display("FAIL orphan_set: got %b expected 1", err_orphan);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (err_orphan !== 1'b1) $display("FAIL orphan_sticky: got %b expected 1", err_orphan);
    else n_pass++;
    reset = 1;
    tick();
    reset = 0;
    #1;
    n_total++;
    if (err_orphan !== 1'b0) $display("FAIL orphan_reset: got %b expected 0", err_orphan);
    else n_pass++;
    ic_bus.req_valid = 1; dc_bus.req_valid = 1;
    #1;
    n_total++;
    if ({ic_bus.req_ready, dc_bus.req_ready} !== 2'b01)
      $display("FAIL reset_tie: got %b expected 01", {ic_bus.req_ready, dc_bus.req_ready});
    else n_pass++;
    tick();
    idle_inputs();
  endtask

  // Randomized traffic against a transaction-level model: reads queue their
  // owner in issue order, a write holds the channel from its first accepted
  // half until its second, and ties go to whoever did not win the last grant.
  task automatic test_random();
    bit act [2], rw [2], adone [2], ddone [2], v [2], dv [2], el [2];
    logic [AB-1:0] addr [2];
    logic [DB-1:0] data [2];
    logic [MB-1:0] mask [2];
    int owners[$];
    int last, lock_owner, g;
    bit m_adone, m_ddone, e_mval, e_dval, e_ahs, e_dhs;
    logic [7:0] exp_v, obs_v;
    logic [DB-1:0] rdata;
    do_reset();
    last = 0; lock_owner = -1; m_adone = 0; m_ddone = 0;
    for (int c = 0; c < 2; c++) begin act[c] = 0; adone[c] = 0; ddone[c] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (!act[c] && $urandom_range(0, 2) == 0) begin
          act[c] = 1; rw[c] = 1'($urandom_range(0, 1)); adone[c] = 0; ddone[c] = 0;
          addr[c] = AB'($urandom); data[c] = {4{$urandom}}; mask[c] = MB'($urandom);
        end
        v[c]  = act[c] & ~adone[c];
        dv[c] = act[c] & rw[c] & ~ddone[c];
      end
      ic_bus.req_valid = v[0]; ic_bus.req_rw = rw[0]; ic_bus.req_addr = addr[0];
      ic_bus.req_data_valid = dv[0]; ic_bus.req_data_bits = data[0]; ic_bus.req_data_mask = mask[0];
      dc_bus.req_valid = v[1]; dc_bus.req_rw = rw[1]; dc_bus.req_addr = addr[1];
      dc_bus.req_data_valid = dv[1]; dc_bus.req_data_bits = data[1]; dc_bus.req_data_mask = mask[1];
      mem_bus.req_ready = ($urandom_range(0, 3) != 0);
      mem_bus.req_data_ready = ($urandom_range(0, 3) != 0);
      mem_bus.resp_valid = (owners.size() > 0) && ($urandom_range(0, 1) == 1);
      rdata = {4{$urandom}};
      mem_bus.resp_data = rdata;

      if (lock_owner >= 0) begin
        g = lock_owner;
        e_mval = v[g] & ~m_adone;
        e_dval = dv[g] & ~m_ddone;
      end else begin
        for (int c = 0; c < 2; c++) el[c] = v[c] & (rw[c] | (owners.size() < DEPTH));
        g = (el[0] && el[1]) ? (1 - last) : (el[1] ? 1 : 0);
        e_mval = el[g];
        e_dval = e_mval & rw[g] & dv[g];
      end
      e_ahs = e_mval & mem_bus.req_ready;
      e_dhs = e_dval & mem_bus.req_data_ready;
      exp_v = {e_mval, e_dval, e_ahs & (g == 0), e_ahs & (g == 1),
               e_dhs & (g == 0), e_dhs & (g == 1),
               mem_bus.resp_valid & (owners.size() > 0) && (owners[0] == 0),
               mem_bus.resp_valid & (owners.size() > 0) && (owners[0] == 1)};
      #1;
      obs_v = {mem_bus.req_valid, mem_bus.req_data_valid, ic_bus.req_ready, dc_bus.req_ready,
               ic_bus.req_data_ready, dc_bus.req_data_ready, ic_bus.resp_valid, dc_bus.resp_valid};
      n_total++;
      if (obs_v !== exp_v) $display("FAIL random_ctrl[%0d]: got %b expected %b", cyc, obs_v, exp_v);
      else n_pass++;
      if (e_mval) begin
        n_total++;
        if ({mem_bus.req_addr, mem_bus.req_rw} !== {addr[g], rw[g]})
          $display("FAIL random_addr[%0d]: got %h/%b expected %h/%b", cyc,
                   mem_bus.req_addr, mem_bus.req_rw, addr[g], rw[g]);
        else n_pass++;
      end
      if (e_dval) begin
        n_total++;
        if ({mem_bus.req_data_bits, mem_bus.req_data_mask} !== {data[g], mask[g]})
          $display("FAIL random_wdata[%0d]: got %h expected %h", cyc,
                   {mem_bus.req_data_bits, mem_bus.req_data_mask}, {data[g], mask[g]});
        else n_pass++;
      end
      if (exp_v[1:0] != 2'b00) begin
        n_total++;
        if ((exp_v[1] ? ic_bus.resp_data : dc_bus.resp_data) !== rdata)
          $display("FAIL random_rdata[%0d]: got %h expected %h", cyc,
                   exp_v[1] ? ic_bus.resp_data : dc_bus.resp_data, rdata);
        else n_pass++;
        void'(owners.pop_front());
      end

      if (lock_owner < 0) begin
        if (e_ahs && !rw[g]) begin
          owners.push_back(g);
          last = g;
        end else if (e_mval && rw[g]) begin
          if (e_ahs && e_dhs) last = g;
          else if (e_ahs || e_dhs) begin
            lock_owner = g; m_adone = e_ahs; m_ddone = e_dhs;
          end
        end
      end else begin
        m_adone = m_adone | e_ahs;
        m_ddone = m_ddone | e_dhs;
        if (m_adone && m_ddone) begin
          last = lock_owner; lock_owner = -1; m_adone = 0; m_ddone = 0;
        end
      end
      if (e_ahs) adone[g] = 1;
      if (e_dhs) ddone[g] = 1;
      for (int c = 0; c < 2; c++)
        if (act[c] && adone[c] && (!rw[c] || ddone[c])) act[c] = 0;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_fifo_full();
    test_split_write();
    test_push_pop_wrap();
    test_orphan_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
